// File: rtl/iob2axi_burst_if.sv
// rtl/iob2axi_burst_if.sv - descriptor, native stream and AXI4 master signals of the burst bridge
// master is the bridge's view; slave is the view of the surrounding system.
interface iob2axi_burst_if #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LEN_W    = 16,
   parameter int AXI_ID_W = 1
);
   logic                  start;
   logic                  dir;
   logic [ADDR_W-1:0]     addr;
   logic [LEN_W-1:0]      len;
   logic                  busy;
   logic                  done;
   logic                  error;

   logic [DATA_W-1:0]     s_wdata;
   logic                  s_wvalid;
   logic                  s_wready;
   logic [DATA_W-1:0]     s_rdata;
   logic                  s_rvalid;
   logic                  s_rready;

   logic [AXI_ID_W-1:0]   m_axi_awid;
   logic [ADDR_W-1:0]     m_axi_awaddr;
   logic [7:0]            m_axi_awlen;
   logic [2:0]            m_axi_awsize;
   logic [1:0]            m_axi_awburst;
   logic                  m_axi_awlock;
   logic [3:0]            m_axi_awcache;
   logic [2:0]            m_axi_awprot;
   logic [3:0]            m_axi_awqos;
   logic                  m_axi_awvalid;
   logic                  m_axi_awready;

   logic [DATA_W-1:0]     m_axi_wdata;
   logic [DATA_W/8-1:0]   m_axi_wstrb;
   logic                  m_axi_wlast;
   logic                  m_axi_wvalid;
   logic                  m_axi_wready;

   logic [1:0]            m_axi_bresp;
   logic                  m_axi_bvalid;
   logic                  m_axi_bready;

   logic [AXI_ID_W-1:0]   m_axi_arid;
   logic [ADDR_W-1:0]     m_axi_araddr;
   logic [7:0]            m_axi_arlen;
   logic [2:0]            m_axi_arsize;
   logic [1:0]            m_axi_arburst;
   logic                  m_axi_arlock;
   logic [3:0]            m_axi_arcache;
   logic [2:0]            m_axi_arprot;
   logic [3:0]            m_axi_arqos;
   logic                  m_axi_arvalid;
   logic                  m_axi_arready;

   logic [DATA_W-1:0]     m_axi_rdata;
   logic [1:0]            m_axi_rresp;
   logic                  m_axi_rlast;
   logic                  m_axi_rvalid;
   logic                  m_axi_rready;

   modport master (
      input  start, dir, addr, len,
      output busy, done, error,
      input  s_wdata, s_wvalid, s_rready,
      output s_wready, s_rdata, s_rvalid,
      output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      input  m_axi_awready,
      output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      input  m_axi_wready,
      input  m_axi_bresp, m_axi_bvalid,
      output m_axi_bready,
      output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
      input  m_axi_arready,
      input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      output m_axi_rready
   );

   modport slave (
      output start, dir, addr, len,
      input  busy, done, error,
      output s_wdata, s_wvalid, s_rready,
      input  s_wready, s_rdata, s_rvalid,
      input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
             m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
      output m_axi_awready,
      input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
      output m_axi_wready,
      output m_axi_bresp, m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
             m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arvalid,
      output m_axi_arready,
      output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
      input  m_axi_rready
   );
endinterface

// File: rtl/iob2axi_burst.sv
// rtl/iob2axi_burst.sv - native descriptor/stream to AXI4 INCR burst master bridge
// One burst outstanding at a time; bursts are capped at MAX_BURST beats and never cross 4 KB.
module iob2axi_burst #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 16,
   parameter int MAX_BURST = 16,
   parameter int AXI_ID_W  = 1,
   parameter int AXI_ID    = 0
) (
   input  logic              clk,
   input  logic              rst,
   iob2axi_burst_if.master   bus
);
   localparam int SIZE = $clog2(DATA_W/8);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  remaining;
   logic [8:0]        burst_beats;
   logic [8:0]        beat_cnt;
   logic              is_write, busy_r, done_r, error_r;

   logic              misaligned, start_ok, last_beat;
   logic              w_hs, r_hs, b_hs, rd_end, burst_end;
   logic [ADDR_W-1:0] addr_adv;
   logic [LEN_W-1:0]  rem_adv;

   function automatic logic [8:0] calc_beats(input logic [11:0] off, input logic [LEN_W-1:0] rem);
      logic [31:0] b, page_words;
      b          = 32'(rem);
      page_words = 32'((13'd4096 - {1'b0, off}) >> SIZE);
      if (page_words < b) b = page_words;
      if (32'(MAX_BURST) < b) b = 32'(MAX_BURST);
      return b[8:0];
   endfunction

   assign misaligned = |bus.addr[SIZE-1:0];
   assign start_ok   = (state == IDLE) && bus.start && !misaligned && (bus.len != '0);
   assign last_beat  = (beat_cnt == 9'd1);
   assign w_hs       = (state == WDATA) && bus.s_wvalid && bus.m_axi_wready;
   assign r_hs       = (state == RDATA) && bus.m_axi_rvalid && bus.s_rready;
   assign b_hs       = (state == WRESP) && bus.m_axi_bvalid;
   // A read burst closes on rlast or on the beat we expected to be last, whichever comes first.
   assign rd_end     = r_hs && (bus.m_axi_rlast || last_beat);
   assign burst_end  = b_hs || rd_end;
   assign addr_adv   = cur_addr + (ADDR_W'(burst_beats) << SIZE);
   assign rem_adv    = remaining - LEN_W'(burst_beats);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_ok) state_nxt = ADDR;
         ADDR:  if (is_write ? bus.m_axi_awready : bus.m_axi_arready)
                   state_nxt = is_write ? WDATA : RDATA;
         WDATA: if (w_hs && last_beat) state_nxt = WRESP;
         WRESP: if (b_hs) state_nxt = (rem_adv == '0) ? IDLE : ADDR;
         RDATA: if (rd_end) state_nxt = (rem_adv == '0) ? IDLE : ADDR;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.m_axi_awvalid = 1'b0;
      bus.m_axi_arvalid = 1'b0;
      bus.m_axi_wvalid  = 1'b0;
      bus.m_axi_wlast   = 1'b0;
      bus.s_wready      = 1'b0;
      bus.m_axi_bready  = 1'b0;
      bus.m_axi_rready  = 1'b0;
      bus.s_rvalid      = 1'b0;
      case (state)
         ADDR: begin
            bus.m_axi_awvalid = is_write;
            bus.m_axi_arvalid = !is_write;
         end
         WDATA: begin
            bus.m_axi_wvalid = bus.s_wvalid;
            bus.s_wready     = bus.m_axi_wready;
            bus.m_axi_wlast  = last_beat;
         end
         WRESP: bus.m_axi_bready = 1'b1;
         RDATA: begin
            bus.m_axi_rready = bus.s_rready;
            bus.s_rvalid     = bus.m_axi_rvalid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_addr    <= '0;
         remaining   <= '0;
         burst_beats <= '0;
         beat_cnt    <= '0;
         is_write    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state == IDLE && bus.start) begin
            is_write    <= bus.dir;
            cur_addr    <= bus.addr;
            remaining   <= bus.len;
            error_r     <= misaligned;
            burst_beats <= calc_beats(bus.addr[11:0], bus.len);
            beat_cnt    <= calc_beats(bus.addr[11:0], bus.len);
            if (misaligned || bus.len == '0) done_r <= 1'b1;
            else                             busy_r <= 1'b1;
         end
         if (w_hs || r_hs) beat_cnt <= beat_cnt - 9'd1;
         if (b_hs && bus.m_axi_bresp != 2'b00) error_r <= 1'b1;
         if (r_hs && bus.m_axi_rresp != 2'b00) error_r <= 1'b1;
         if (rd_end && (bus.m_axi_rlast != last_beat)) error_r <= 1'b1;
         if (burst_end) begin
            cur_addr    <= addr_adv;
            remaining   <= rem_adv;
            burst_beats <= calc_beats(addr_adv[11:0], rem_adv);
            beat_cnt    <= calc_beats(addr_adv[11:0], rem_adv);
            if (rem_adv == '0) begin
               busy_r <= 1'b0;
               done_r <= 1'b1;
            end
         end
      end
   end

   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.error         = error_r;
   assign bus.s_rdata       = bus.m_axi_rdata;
   assign bus.m_axi_wdata   = bus.s_wdata;
   assign bus.m_axi_wstrb   = '1;

   assign bus.m_axi_awid    = AXI_ID_W'(AXI_ID);
   assign bus.m_axi_awaddr  = cur_addr;
   assign bus.m_axi_awlen   = 8'(burst_beats - 9'd1);
   assign bus.m_axi_awsize  = 3'(SIZE);
   assign bus.m_axi_awburst = 2'b01;
   assign bus.m_axi_awlock  = 1'b0;
   assign bus.m_axi_awcache = 4'b0011;
   assign bus.m_axi_awprot  = 3'b000;
   assign bus.m_axi_awqos   = 4'b0000;

   assign bus.m_axi_arid    = AXI_ID_W'(AXI_ID);
   assign bus.m_axi_araddr  = cur_addr;
   assign bus.m_axi_arlen   = 8'(burst_beats - 9'd1);
   assign bus.m_axi_arsize  = 3'(SIZE);
   assign bus.m_axi_arburst = 2'b01;
   assign bus.m_axi_arlock  = 1'b0;
   assign bus.m_axi_arcache = 4'b0011;
   assign bus.m_axi_arprot  = 3'b000;
   assign bus.m_axi_arqos   = 4'b0000;
endmodule

// File: tb/tb_iob2axi_burst.sv
// tb/tb_iob2axi_burst.sv - directed bench for iob2axi_burst with an AXI slave and native stream model
// The model drives on the falling edge and records handshakes due at the following rising edge.
module tb_iob2axi_burst;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   iob2axi_burst_if bus ();
   iob2axi_burst dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk = 0;
   int n_bad = 0;

   int cyc = 0, done_cnt = 0, done_cyc = 0, bhs_cyc = 0, start_cyc = 0;
   int busy_cyc = 0, busy_with_done = 0, traffic = 0, bad_attr = 0;
   int w_idx = 0, n_words = 0, r_left = 0, r_beat = 0, err_beat = -1;
   bit stall = 1'b0, b_pending = 1'b0, rv_hold = 1'b0;
   logic [31:0] r_addr = '0;
   logic [31:0] aw_addr_q[$], aw_len_q[$], ar_addr_q[$], ar_len_q[$];
   logic [31:0] w_data_q[$], w_last_q[$], rd_q[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] wpat(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   function automatic logic [9:0] idle_outs();
      return {bus.busy, bus.done, bus.error, bus.m_axi_awvalid, bus.m_axi_arvalid,
              bus.m_axi_wvalid, bus.s_wready, bus.m_axi_bready, bus.m_axi_rready, bus.s_rvalid};
   endfunction

   always @(negedge clk) begin
      cyc++;
      bus.m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axi_arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axi_wready  = 1'b1;
      bus.m_axi_bvalid  = b_pending;
      bus.m_axi_bresp   = 2'b00;
      if (r_left > 0) begin
         bus.m_axi_rvalid = rv_hold ? 1'b1 : (stall ? 1'($urandom_range(0, 1)) : 1'b1);
         bus.m_axi_rdata  = r_addr ^ 32'h5A5A_0000;
         bus.m_axi_rlast  = (r_left == 1);
         bus.m_axi_rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
         bus.m_axi_rvalid = 1'b0;
         bus.m_axi_rdata  = '0;
         bus.m_axi_rlast  = 1'b0;
         bus.m_axi_rresp  = 2'b00;
      end
      bus.s_wvalid = (w_idx < n_words);
      bus.s_wdata  = wpat(w_idx);
      bus.s_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
         if (bus.busy) busy_with_done++;
      end
      if (bus.m_axi_awvalid || bus.m_axi_arvalid || bus.m_axi_wvalid || bus.m_axi_bready || bus.m_axi_rready)
         traffic++;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
         aw_addr_q.push_back(bus.m_axi_awaddr);
         aw_len_q.push_back(32'(bus.m_axi_awlen));
         if (bus.m_axi_awsize != 3'd2 || bus.m_axi_awburst != 2'b01) bad_attr++;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
         w_data_q.push_back(bus.m_axi_wdata);
         w_last_q.push_back(32'(bus.m_axi_wlast));
         if (bus.m_axi_wstrb != 4'hF) bad_attr++;
         w_idx++;
         if (bus.m_axi_wlast) b_pending = 1'b1;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) begin
         b_pending = 1'b0;
         bhs_cyc   = cyc;
      end
      rv_hold = bus.m_axi_rvalid && !bus.m_axi_rready;
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
         r_left--;
         r_addr += 32'd4;
         r_beat++;
      end
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
         ar_addr_q.push_back(bus.m_axi_araddr);
         ar_len_q.push_back(32'(bus.m_axi_arlen));
         if (bus.m_axi_arsize != 3'd2 || bus.m_axi_arburst != 2'b01) bad_attr++;
         r_left  = int'(bus.m_axi_arlen) + 1;
         r_addr  = bus.m_axi_araddr;
         rv_hold = 1'b0;
      end
      if (bus.s_rvalid && bus.s_rready) rd_q.push_back(bus.s_rdata);
   end

   task automatic clear_model();
      aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
      w_data_q.delete(); w_last_q.delete(); rd_q.delete();
      w_idx = 0; n_words = 0; r_left = 0; r_beat = 0; b_pending = 1'b0; rv_hold = 1'b0;
   endtask

   task automatic run_xfer(input logic d, input logic [31:0] a, input logic [15:0] l, input string tag);
      int d0;
      bit seen;
      d0 = done_cnt;
      @(negedge clk); #2;
      bus.dir = d; bus.addr = a; bus.len = l; bus.start = 1'b1;
      start_cyc = cyc;
      @(negedge clk); #2;
      bus.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         if (done_cnt != d0) seen = 1'b1;
         else begin @(negedge clk); #2; end
      end
      check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      #2 check_eq({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int t0, b0;
      bit hit;
      bus.start = 1'b0; bus.dir = 1'b0; bus.addr = '0; bus.len = '0;
      repeat (3) @(negedge clk);
      #2;
      check_eq("reset_outs", 32'(idle_outs()), 32'd0);
      check_eq("awcache_const", 32'(bus.m_axi_awcache), 32'd3);
      rst = 1'b1;

      // single write burst
      clear_model(); n_words = 4;
      run_xfer(1'b1, 32'h1000, 16'd4, "wr4");
      check_eq("wr4_aw_cnt", 32'(aw_addr_q.size()), 32'd1);
      check_eq("wr4_awaddr", qget(aw_addr_q, 0), 32'h1000);
      check_eq("wr4_awlen", qget(aw_len_q, 0), 32'd3);
      check_eq("wr4_w_cnt", 32'(w_data_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("wr4_wdata%0d", i), qget(w_data_q, i), wpat(i));
         check_eq($sformatf("wr4_wlast%0d", i), qget(w_last_q, i), 32'(i == 3));
      end
      check_eq("wr4_done_after_b", 32'(done_cyc - bhs_cyc), 32'd1);
      check_eq("wr4_error", 32'(bus.error), 32'd0);
      check_eq("wr4_busy_after", 32'(bus.busy), 32'd0);

      // read split by MAX_BURST
      clear_model();
      run_xfer(1'b0, 32'h0, 16'd40, "rd40");
      check_eq("rd40_ar_cnt", 32'(ar_addr_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("rd40_araddr%0d", i), qget(ar_addr_q, i), 32'(i * 64));
         check_eq($sformatf("rd40_arlen%0d", i), qget(ar_len_q, i), (i < 2) ? 32'd15 : 32'd7);
      end
      check_eq("rd40_word_cnt", 32'(rd_q.size()), 32'd40);
      for (int i = 0; i < 40; i++)
         check_eq($sformatf("rd40_data%0d", i), qget(rd_q, i), 32'(i * 4) ^ 32'h5A5A_0000);
      check_eq("rd40_error", 32'(bus.error), 32'd0);

      // write split at the 4 KB boundary
      clear_model(); n_words = 6;
      run_xfer(1'b1, 32'h0FF8, 16'd6, "wr4k");
      check_eq("wr4k_aw_cnt", 32'(aw_addr_q.size()), 32'd2);
      check_eq("wr4k_awaddr0", qget(aw_addr_q, 0), 32'h0FF8);
      check_eq("wr4k_awlen0", qget(aw_len_q, 0), 32'd1);
      check_eq("wr4k_awaddr1", qget(aw_addr_q, 1), 32'h1000);
      check_eq("wr4k_awlen1", qget(aw_len_q, 1), 32'd3);
      check_eq("wr4k_w_cnt", 32'(w_data_q.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("wr4k_wdata%0d", i), qget(w_data_q, i), wpat(i));
         check_eq($sformatf("wr4k_wlast%0d", i), qget(w_last_q, i), 32'(i == 1 || i == 5));
      end

      // read with SLVERR on the second beat and random stalls
      clear_model(); stall = 1'b1; err_beat = 1;
      run_xfer(1'b0, 32'h100, 16'd20, "rderr");
      stall = 1'b0; err_beat = -1;
      check_eq("rderr_ar_cnt", 32'(ar_addr_q.size()), 32'd2);
      check_eq("rderr_arlen1", qget(ar_len_q, 1), 32'd3);
      check_eq("rderr_word_cnt", 32'(rd_q.size()), 32'd20);
      for (int i = 0; i < 20; i++)
         check_eq($sformatf("rderr_data%0d", i), qget(rd_q, i), (32'h100 + 32'(i * 4)) ^ 32'h5A5A_0000);
      check_eq("rderr_error", 32'(bus.error), 32'd1);

      // len=0: clears error, done next cycle, no traffic, busy never rises
      clear_model(); t0 = traffic; b0 = busy_cyc;
      run_xfer(1'b0, 32'h200, 16'd0, "len0");
      check_eq("len0_error_cleared", 32'(bus.error), 32'd0);
      check_eq("len0_done_latency", 32'(done_cyc - start_cyc), 32'd1);
      check_eq("len0_traffic", 32'(traffic - t0), 32'd0);
      check_eq("len0_busy", 32'(busy_cyc - b0), 32'd0);

      // misaligned start address
      clear_model(); t0 = traffic;
      run_xfer(1'b1, 32'h3, 16'd4, "unal");
      check_eq("unal_error", 32'(bus.error), 32'd1);
      check_eq("unal_done_latency", 32'(done_cyc - start_cyc), 32'd1);
      check_eq("unal_traffic", 32'(traffic - t0), 32'd0);

      // asynchronous reset in the middle of a write burst
      clear_model(); n_words = 8;
      @(negedge clk); #2;
      bus.dir = 1'b1; bus.addr = 32'h2000; bus.len = 16'd8; bus.start = 1'b1;
      @(negedge clk); #2;
      bus.start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         if (w_data_q.size() >= 2) hit = 1'b1;
         else begin @(negedge clk); #2; end
      end
      check_eq("mid_wdata_reached", 32'(hit), 32'd1);
      #1 rst = 1'b0;
      #1 check_eq("async_rst_outs", 32'(idle_outs()), 32'd0);
      repeat (2) @(negedge clk);
      clear_model();
      #2 rst = 1'b1;
      n_words = 4;
      run_xfer(1'b1, 32'h1000, 16'd4, "post_rst");
      check_eq("post_rst_aw_cnt", 32'(aw_addr_q.size()), 32'd1);
      check_eq("post_rst_awaddr", qget(aw_addr_q, 0), 32'h1000);
      check_eq("post_rst_w_cnt", 32'(w_data_q.size()), 32'd4);
      check_eq("post_rst_error", 32'(bus.error), 32'd0);

      check_eq("done_while_busy", 32'(busy_with_done), 32'd0);
      check_eq("axi_attr_bad", 32'(bad_attr), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/iob2axi_burst.md
Name: iob2axi_burst

Overview:
- Native-to-AXI4-full master bridge, successor to the per-access bridge.
- Accepts one descriptor (address, word count, direction) and streams the data through a native valid/ready port.
- Splits each transfer into AXI INCR bursts, each capped at MAX_BURST beats and never crossing a 4 KB boundary.
- Sits between DMA-style accelerators and the system AXI interconnect.
- Single engine: one direction is active at a time.

Parameters:
- ADDR_W 32: byte-address width; AXI address width is equal to it.
- DATA_W 32: data width in bits; must be 32, 64 or 128.
- LEN_W 16: width of the word-count field.
- MAX_BURST 16: maximum beats per burst; power of two, range 1..256.
- AXI_ID_W 1: AXI ID width.
- AXI_ID 0: constant ID driven on AWID and ARID.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle descriptor strobe
- dir  in  1  transfer direction: 1 = write to AXI, 0 = read from AXI
- addr  in  ADDR_W  start byte address
- len  in  LEN_W  number of DATA_W words to transfer
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse at completion
- error  out  1  sticky error flag
- s_wdata, s_wvalid, s_wready  in/in/out  DATA_W/1/1  native write stream
- s_rdata, s_rvalid, s_rready  out/out/in  DATA_W/1/1  native read stream
- m_axi_aw{addr,len,size,burst,valid}/awready  out/in  AXI4 write-address channel signals
- m_axi_w{data,strb,last,valid}/wready  out/in  AXI4 write-data channel signals
- m_axi_b{resp,valid}/bready  in/out  AXI4 write-response channel signals
- m_axi_ar{addr,len,size,burst,valid}/arready  out/in  AXI4 read-address channel signals
- m_axi_r{data,resp,last,valid}/rready  in/out  AXI4 read-data channel signals
- m_axi_{aw,ar}{id,lock,cache,prot,qos}  out  constants: AXI_ID, 0, 4'b0011, 3'b000, 0

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy, done, error, all AXI valid/ready outputs, s_wready and s_rvalid are 0.
- FSM states: IDLE, ADDR, WDATA, WRESP, RDATA.
- IDLE:
  - start=1 latches addr and len, clears error, and sets busy the next cycle.
  - len=0: no AXI traffic; done pulses the next cycle; busy stays 0.
  - addr not aligned to DATA_W/8: error=1, done pulses, no AXI traffic.
  - start while busy is ignored.
- Beats per burst = min(remaining, MAX_BURST, (4096 - addr[11:0]) >> log2(DATA_W/8)).
  - AxLEN = beats - 1.
  - AxSIZE = log2(DATA_W/8).
  - AxBURST = INCR.
- ADDR: drive awvalid or arvalid with the registered burst fields, which are stable until the handshake; then go to WDATA or RDATA.
- WDATA:
  - m_axi_wvalid = s_wvalid and s_wready = m_axi_wready (combinational pass-through).
  - wstrb is all ones; wlast is asserted on the final beat of the burst.
  - A beat counter decrements on each W handshake.
  - After the last beat, go to WRESP.
- WRESP:
  - bready = 1.
  - On bvalid, a bresp other than OKAY sets error.
  - Address advances by beats*DATA_W/8 and remaining decrements by beats.
  - If remaining is 0: go to IDLE and pulse done. Otherwise go to ADDR.
- RDATA:
  - s_rvalid = m_axi_rvalid, m_axi_rready = s_rready, s_rdata = m_axi_rdata.
  - Any beat with rresp other than OKAY sets error.
  - On rlast, advance the counters; if remaining is 0, go to IDLE with a done pulse, otherwise go to ADDR.
  - If rlast does not arrive on the expected final beat: set error, then follow the same counter update.
- An error never aborts a transfer; all words are still transferred.
- Only one burst is outstanding at a time; no AW/W overlap.
- done is registered and is high exactly one cycle, in the cycle busy falls.
- Native stream ports are idle (s_wready=0, s_rvalid=0) outside WDATA and RDATA.

Test Plan:
- Write, addr=0x1000, len=4, DATA_W=32, always-ready slave -> one AW (awlen=3, awsize=2); 4 W beats with wlast on the 4th; done pulses one cycle after the B handshake; error=0.
- Read, addr=0x0, len=40, MAX_BURST=16 -> three ARs with arlen 15, 15, 7 at addresses 0x0, 0x40, 0x80; 40 words delivered in order.
- Write, addr=0x0FF8, len=6 -> bursts split at 4 KB: awlen=1 at 0x0FF8, then awlen=3 at 0x1000.
- Read where the slave returns rresp=SLVERR on beat 2, with random rvalid and s_rready stalls -> all beats delivered; error=1 after done; the next start clears error.
- len=0 -> done pulses the next cycle with no AXI valids asserted. addr=0x3 -> error=1 plus done, no traffic.
- rst driven low in the middle of a WDATA burst -> all outputs 0 immediately (asynchronously); after release, state is IDLE and a new start is accepted.
